mmio_responder: RTL and testbench
=================================

// Module: mmio_responder
// PURPOSE
//  Memory-mapped I/O responder on the CPU data-memory interface (addr/wdata/mm_we/mm_re/rdata).
//  Decodes a 16-word I/O window, serves CPU reads and writes with zero wait states, and bridges
//  to a byte-wide TX stream and RX stream through two small FIFOs. Also provides a compare timer
//  with interrupt. Sits beside data memory; the top level muxes rdata by address range.
// PARAMETERS
//  BASE_ADDR   16'hC000  base of I/O window (aligned to 16 words); decode is addr[15:4]==BASE_ADDR[15:4]
//  FIFO_DEPTH  4         entries per TX/RX FIFO (power of 2, >=2)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  addr       in   16  CPU word address
//  wdata      in   16  CPU write data
//  mm_we      in   1   CPU write strobe, one cycle per access
//  mm_re      in   1   CPU read strobe, one cycle per access
//  rdata      out  16  read data, valid same cycle as mm_re
//  tx_data    out  8   TX FIFO head byte
//  tx_valid   out  1   TX FIFO not empty
//  tx_ready   in   1   sink accepts head byte when tx_valid&tx_ready at posedge
//  rx_data    in   8   incoming byte
//  rx_valid   in   1   incoming byte present
//  rx_ready   out  1   RX FIFO not full; byte captured when rx_valid&rx_ready at posedge
//  irq        out  1   registered interrupt = tmr_flag & irq_en
// BEHAVIOUR
//  Clock/reset: single clock clk; rst_n asynchronous, active-low. Reset: FIFOs empty, TIMER=0,
//   TCMP=16'hFFFF, CTRL=0, ovf flags=0 -> tx_valid=0, tx_data=8'h00, rx_ready=1, irq=0, rdata=0.
//  Register map (offset from BASE_ADDR):
//   0 TXDATA  W: push wdata[7:0] to TX FIFO.            R: 16'h0000
//   1 RXDATA  R: {8'h00,head}, pops RX FIFO at posedge.  W: ignored
//   2 STATUS  R: {4'b0,tx_cnt[2:0],rx_cnt[2:0],tx_ovf,rx_ovf,tx_full,tx_empty,rx_full,rx_empty}
//             W: any write clears tx_ovf and rx_ovf
//   3 TIMER   R/W: 16-bit counter value
//   4 TCMP    R/W: compare value
//   5 CTRL    R: {13'b0,tmr_flag,irq_en,tmr_en}; W: bit0 tmr_en, bit1 irq_en, bit2=1 clears tmr_flag
//   6..15     R: 16'h0000, W: ignored
//  rdata: combinational from registered state; 16'h0000 when mm_re=0 or addr outside window.
//  Read side effects (RX pop) and all writes commit at the posedge ending the access cycle.
//  mm_we & mm_re same cycle: write performed, read side effect suppressed, rdata still driven.
//  TX FIFO: CPU push when full and no same-cycle sink pop -> byte dropped, tx_ovf<=1 (sticky).
//   Full with same-cycle pop -> push accepted, count unchanged. tx_data = head, 8'h00 when empty.
//  RX FIFO: rx_ready = !rx_full (combinational from count, no dependence on rx_valid).
//   RXDATA read when empty -> 16'h0000, no state change. Overrun impossible at interface;
//   rx_ovf set if rx_valid=1 while rx_full (byte not captured). Push+pop same cycle allowed.
//  Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1, zero-extended into STATUS.
//  Timer: if tmr_en, TIMER increments each cycle; when TIMER==TCMP: next TIMER=0, tmr_flag<=1.
//   CPU write to TIMER wins over increment/wrap; that cycle sets no flag. Flag-clear write and
//   a same-cycle match -> flag stays 1 (set wins). TCMP=0 with tmr_en -> flag every cycle.
//  irq: registered, one cycle after tmr_flag/irq_en change; deasserts cycle after clear.
//  Reset mid-operation: all state returns to reset values immediately; in-flight bytes lost.
// STRUCTURE
//  Package mmio_pkg: offset localparams (OFS_TXDATA..OFS_CTRL), STATUS/CTRL bit index constants.
//  Sub-module sync_fifo #(WIDTH,DEPTH): push/pop/full/empty/count/head; instantiated for TX and RX.
//  Top holds decode, register file, timer, rdata mux, ovf logic.
// TESTING
//  1 Reset: hold rst_n=0 mid-run -> tx_valid=0, rx_ready=1, irq=0, STATUS reads 16'h0005.
//  2 TX: tx_ready=0, write 0x41,0x42,0x43,0x44,0x45 to C000 -> STATUS tx_full=1,tx_ovf=1,tx_cnt=4;
//    raise tx_ready -> sink sees 41,42,43,44 then tx_valid=0; write C002 -> tx_ovf=0.
//  3 RX: drive 0x5A,0xA5 -> read C001 returns 005A then 00A5; third read 0000, rx_empty=1.
//  4 RX full: 5 bytes with rx_valid held -> rx_ready=0 after 4th, rx_ovf=1, reads return first 4.
//  5 Timer: TCMP=3, CTRL=3 -> TIMER 0,1,2,3,0; tmr_flag set at wrap, irq=1 one cycle later;
//    write CTRL=7 -> irq=0 next cycle.
//  6 Same cycle: mm_we&mm_re to C001 -> RX count unchanged; TIMER write on match -> no flag.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register offsets, STATUS/CTRL bit
// positions and the CPU access request bundle.
package mmio_pkg;

  // Register offsets within the 16-word I/O window
  localparam logic [3:0] OFS_TXDATA = 4'd0;
  localparam logic [3:0] OFS_RXDATA = 4'd1;
  localparam logic [3:0] OFS_STATUS = 4'd2;
  localparam logic [3:0] OFS_TIMER  = 4'd3;
  localparam logic [3:0] OFS_TCMP   = 4'd4;
  localparam logic [3:0] OFS_CTRL   = 4'd5;

  // STATUS bit positions (counts are 3-bit fields starting at these bits)
  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_CNT   = 6;
  localparam int ST_TX_CNT   = 9;

  // CTRL bit positions
  localparam int CT_TMR_EN = 0;
  localparam int CT_IRQ_EN = 1;
  localparam int CT_FLAG   = 2;

  // One CPU data-memory access
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
  } mmio_req_t;

endpackage

// File: rtl/mmio_responder_fifo.sv
// Small synchronous FIFO with registered storage. Push is accepted when not
// full, or when full but a pop happens in the same cycle. Head reads as zero
// when empty so downstream never sees stale bytes.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers (wrap by power-of-2 width) and count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset empties the FIFO and drops in-flight data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: decodes a 16-word window on the CPU data bus, bridges to
// byte-wide TX/RX streams through FIFOs, and hosts a compare timer with irq.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hC000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  output logic [15:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  mmio_req_t   req;
  logic        in_win, wr_hit, rd_hit;
  logic [3:0]  ofs;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [7:0]  rx_head;
  logic [15:0] status;
  logic        tmr_match, timer_wr;

  logic [15:0] timer_q, timer_d, tcmp_q, tcmp_d;
  logic        tmr_en_q, tmr_en_d, irq_en_q, irq_en_d, tmr_flag_q, tmr_flag_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, irq_q, irq_d;

  assign req    = '{addr: addr, wdata: wdata, we: mm_we, re: mm_re};
  assign in_win = (req.addr[15:4] == BASE_ADDR[15:4]);
  assign ofs    = req.addr[3:0];
  assign wr_hit = req.we && in_win;
  assign rd_hit = req.re && in_win;

  // A read that coincides with a write keeps its data but loses its pop
  assign tx_push  = wr_hit && (ofs == OFS_TXDATA);
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_valid = !tx_empty;
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = rd_hit && !req.we && (ofs == OFS_RXDATA);
  assign rx_ready = !rx_full;
  assign irq      = irq_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .wdata(req.wdata[7:0]), .pop(tx_pop),
    .full(tx_full), .empty(tx_empty), .count(tx_cnt), .head(tx_data)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .wdata(rx_data), .pop(rx_pop),
    .full(rx_full), .empty(rx_empty), .count(rx_cnt), .head(rx_head)
  );

  assign timer_wr  = wr_hit && (ofs == OFS_TIMER);
  assign tmr_match = tmr_en_q && (timer_q == tcmp_q);

  // Register-file, timer, sticky-flag and irq next-state; set beats clear
  always_comb begin
    timer_d    = timer_q;
    tcmp_d     = tcmp_q;
    tmr_en_d   = tmr_en_q;
    irq_en_d   = irq_en_q;
    tmr_flag_d = tmr_flag_q;
    tx_ovf_d   = tx_ovf_q;
    rx_ovf_d   = rx_ovf_q;
    if (timer_wr)         timer_d = req.wdata;
    else if (tmr_match)   timer_d = '0;
    else if (tmr_en_q)    timer_d = timer_q + 16'd1;
    if (wr_hit && ofs == OFS_TCMP) tcmp_d = req.wdata;
    if (wr_hit && ofs == OFS_CTRL) begin
      tmr_en_d = req.wdata[CT_TMR_EN];
      irq_en_d = req.wdata[CT_IRQ_EN];
      if (req.wdata[CT_FLAG]) tmr_flag_d = 1'b0;
    end
    if (tmr_match && !timer_wr) tmr_flag_d = 1'b1;
    if (wr_hit && ofs == OFS_STATUS) begin
      tx_ovf_d = 1'b0;
      rx_ovf_d = 1'b0;
    end
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_valid && rx_full)           rx_ovf_d = 1'b1;
    irq_d = tmr_flag_q & irq_en_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q    <= '0;
      tcmp_q     <= 16'hFFFF;
      tmr_en_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      tmr_flag_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      tcmp_q     <= tcmp_d;
      tmr_en_q   <= tmr_en_d;
      irq_en_q   <= irq_en_d;
      tmr_flag_q <= tmr_flag_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      irq_q      <= irq_d;
    end
  end

  assign status = {4'b0, 3'(tx_cnt), 3'(rx_cnt), tx_ovf_q, rx_ovf_q,
                   tx_full, tx_empty, rx_full, rx_empty};

  // Read mux: zero unless an in-window read is active
  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (ofs)
        OFS_RXDATA: rdata = {8'h00, rx_head};
        OFS_STATUS: rdata = status;
        OFS_TIMER:  rdata = timer_q;
        OFS_TCMP:   rdata = tcmp_q;
        OFS_CTRL:   rdata = {13'b0, tmr_flag_q, irq_en_q, tmr_en_q};
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: stimulus queues expected read data,
// TX bytes and pin values; a negedge monitor pops and compares them.
module tb_mmio_responder;
  logic        clk, rst_n;
  logic [15:0] addr, wdata, rdata;
  logic        mm_we, mm_re;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
  logic        done;

  typedef struct {
    int          id;
    logic [15:0] val;
    string       name;
  } pchk_t;

  pchk_t       pq[$];
  logic [15:0] rq[$];
  logic [7:0]  tq[$];
  int          n_cmp, n_bad;

  mmio_responder #(.BASE_ADDR(16'hC000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mm_we(mm_we),
    .mm_re(mm_re), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int cyc;
    pchk_t p;
    logic [15:0] act;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    forever begin
      @(negedge clk);
      cyc++;
      while (pq.size() > 0) begin
        p = pq.pop_front();
        case (p.id)
          0:       act = {15'b0, tx_valid};
          1:       act = {15'b0, rx_ready};
          2:       act = {15'b0, irq};
          default: act = {8'b0, tx_data};
        endcase
        cmp(p.name, act, p.val);
      end
      if (mm_re) begin
        if (rq.size() == 0) cmp("unexpected_read", rdata, 16'hxxxx);
        else cmp($sformatf("rdata@%h", addr), rdata, rq.pop_front());
      end
      if (tx_valid && tx_ready) begin
        if (tq.size() == 0) cmp("unexpected_tx", {8'b0, tx_data}, 16'hxxxx);
        else cmp("tx_byte", {8'b0, tx_data}, {8'b0, tq.pop_front()});
      end
      if (done || cyc > 4000) begin
        if (!done) cmp("timeout", 16'd0, 16'd1);
        cmp("leftover_expectations", 16'(rq.size() + tq.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e);
    addr  = a;
    mm_re = 1'b1;
    rq.push_back(e);
    tick();
    mm_re = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    mm_we = 1'b1;
    tick();
    mm_we = 1'b0;
  endtask

  task automatic pchk(input int id, input logic [15:0] v, input string name);
    pq.push_back('{id, v, name});
  endtask

  initial begin
    done = 1'b0;
    rst_n = 1'b0; addr = '0; wdata = '0; mm_we = 1'b0; mm_re = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick(); tick();
    rst_n = 1'b1;

    // reset state and decode
    pchk(0, 16'd0, "tx_valid_rst"); pchk(1, 16'd1, "rx_ready_rst");
    pchk(2, 16'd0, "irq_rst");      pchk(3, 16'd0, "tx_data_rst");
    rd(16'hC002, 16'h0005);
    rd(16'hC004, 16'hFFFF);
    rd(16'hC005, 16'h0000);
    wr(16'hD003, 16'h1234);          // outside window
    rd(16'hC003, 16'h0000);
    rd(16'hC010, 16'h0000);
    rd(16'hC007, 16'h0000);
    rd(16'hC000, 16'h0000);

    // TX overflow then drain
    for (int i = 0; i < 5; i++) wr(16'hC000, 16'h0041 + 16'(i));
    pchk(0, 16'd1, "tx_valid_full"); pchk(3, 16'h0041, "tx_head");
    rd(16'hC002, 16'h0829);
    for (int i = 0; i < 4; i++) tq.push_back(8'h41 + 8'(i));
    tx_ready = 1'b1;
    repeat (6) tick();
    pchk(0, 16'd0, "tx_valid_drained");
    tx_ready = 1'b0;
    wr(16'hC002, 16'h0000);
    rd(16'hC002, 16'h0005);

    // TX push while full with same-cycle pop
    for (int i = 1; i <= 4; i++) wr(16'hC000, 16'(i));
    for (int i = 1; i <= 5; i++) tq.push_back(8'(i));
    tx_ready = 1'b1;
    wr(16'hC000, 16'h0005);
    tx_ready = 1'b0;
    rd(16'hC002, 16'h0809);
    tx_ready = 1'b1;
    repeat (6) tick();
    tx_ready = 1'b0;

    // RX basic
    rx_valid = 1'b1; rx_data = 8'h5A; tick();
    rx_data = 8'hA5; tick();
    rx_valid = 1'b0;
    rd(16'hC001, 16'h005A);
    rd(16'hC001, 16'h00A5);
    rd(16'hC001, 16'h0000);
    rd(16'hC002, 16'h0005);

    // RX full / overrun, then write+read same cycle on RXDATA
    rx_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin rx_data = 8'(i * 8'h11); tick(); end
    pchk(1, 16'd0, "rx_ready_full");
    rx_data = 8'h55; tick();
    rx_valid = 1'b0;
    addr = 16'hC001; mm_we = 1'b1; mm_re = 1'b1; rq.push_back(16'h0011);
    tick();
    mm_we = 1'b0; mm_re = 1'b0;
    rd(16'hC002, 16'h0116);
    for (int i = 1; i <= 4; i++) rd(16'hC001, 16'(i * 16'h11));
    rd(16'hC001, 16'h0000);
    pchk(1, 16'd1, "rx_ready_drained");
    wr(16'hC002, 16'h0000);
    rd(16'hC002, 16'h0005);

    // Timer compare, flag, irq
    wr(16'hC004, 16'd3);
    wr(16'hC005, 16'd3);
    for (int i = 0; i < 4; i++) rd(16'hC003, 16'(i));
    pchk(2, 16'd0, "irq_before");
    rd(16'hC005, 16'h0007);
    pchk(2, 16'd1, "irq_set");
    wr(16'hC005, 16'h0007);
    rd(16'hC005, 16'h0003);
    pchk(2, 16'd0, "irq_cleared");
    tick();
    wr(16'hC005, 16'h0004);
    rd(16'hC005, 16'h0000);
    rd(16'hC003, 16'h0001);
    // TIMER write on a match cycle: no flag
    wr(16'hC003, 16'd3);
    wr(16'hC005, 16'h0001);
    wr(16'hC003, 16'h0010);
    rd(16'hC005, 16'h0001);
    rd(16'hC003, 16'h0011);
    // flag clear on a match cycle: set wins
    wr(16'hC005, 16'h0000);
    wr(16'hC003, 16'd3);
    wr(16'hC005, 16'h0001);
    wr(16'hC005, 16'h0005);
    rd(16'hC005, 16'h0005);
    wr(16'hC005, 16'h0004);
    rd(16'hC005, 16'h0000);
    // TCMP=0: match every cycle
    wr(16'hC003, 16'd0);
    wr(16'hC004, 16'd0);
    wr(16'hC005, 16'h0001);
    wr(16'hC005, 16'h0005);
    rd(16'hC005, 16'h0005);

    // Reset mid-operation
    wr(16'hC000, 16'h0077);
    rx_valid = 1'b1; rx_data = 8'h66; tick();
    rx_valid = 1'b0;
    wr(16'hC005, 16'h0003);
    repeat (3) tick();
    rst_n = 1'b0;
    pchk(0, 16'd0, "tx_valid_midrst"); pchk(1, 16'd1, "rx_ready_midrst");
    pchk(2, 16'd0, "irq_midrst");      pchk(3, 16'd0, "tx_data_midrst");
    tick(); tick();
    rst_n = 1'b1;
    rd(16'hC002, 16'h0005);
    rd(16'hC004, 16'hFFFF);
    rd(16'hC005, 16'h0000);
    rd(16'hC003, 16'h0000);
    tick();
    done = 1'b1;
  end

endmodule
